ram_master: RTL
===============

Name: ram_master

Overview:
Request-side initiator for the SRAM driver. It sits between the MEM stage and the driver's ce/we/addr/data/ready interface. It turns one CPU memory request (word, halfword or byte; load or store) into one or two driver accesses, with read-modify-write for sub-word stores, and returns the aligned, extended load data with a single-cycle completion pulse.

Parameters:
TIMEOUT_CYCLES, 15, watchdog limit in cycles per access (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_i  in  1  request; held by requester until done_o
op_i  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
addr_i  in  32  byte address
wdata_i  in  32  store data, low-aligned (SB uses [7:0], SH uses [15:0])
rdata_o  out  32  load result, valid while done_o=1
done_o  out  1  one-cycle completion pulse
err_o  out  1  misaligned or timeout, valid with done_o
busy_o  out  1  state != IDLE
ram_ce_o  out  1  driver enable
ram_we_o  out  1  1=write, 0=read
ram_addr_o  out  32  word address to driver ({addr[31:2],2'b00})
ram_data_o  out  32  write word to driver
ram_ready_i  in  1  driver ready
ram_data_i  in  32  driver read word

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; latched op/addr/wdata/word registers 0. If reset arrives mid-access, ram_ce_o drops immediately and the access is abandoned with no done_o.
- States: IDLE, RD, GAP, WR, DONE. ram_ce_o=1 only in RD/WR. ram_we_o=1 only in WR. Both are decoded combinationally from the state.
- Driver protocol: ready stays high while ce stays high. Every access therefore ends with at least one edge at ce=0 (GAP or DONE) before the next ce=1.
- IDLE: if req_i=1, latch op/addr/wdata.
  - If misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0), go to DONE with err=1 and make no driver access.
  - Otherwise go to RD for loads, SB and SH; go to WR for SW.
- RD: hold ce=1, we=0. On ram_ready_i=1, capture ram_data_i into word_r.
  - Loads go to DONE.
  - SB/SH go to GAP.
- GAP: ce=0 for one cycle. Merge store data into word_r, then go to WR.
- WR: ce=1, we=1, ram_data_o=word_r (or wdata for SW). On ram_ready_i=1, go to DONE.
- DONE: done_o=1 and ce=0 for exactly one cycle, then go to IDLE. req_i is ignored in DONE, so the requester deasserts or re-presents the request for IDLE.
- Byte lanes are little-endian: addr[1:0]=0 maps to bits[7:0], 3 maps to [31:24]. Halfword addr[1]=0 maps to [15:0].
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- SB/SH merge replaces only the addressed lane(s) in word_r. Other bits keep the read value.
- Latency with a one-cycle driver (ready one edge after ce rises):
  - Loads and SW: done_o is high in the cycle after the 2nd edge following acceptance.
  - SB/SH: done_o is high after the 5th edge.
- rdata_o=0 for stores and on error.

Optional Feature:
RAM_MASTER_TIMEOUT_EN.
- Defined: a 4-bit counter clears on entry to RD/WR and increments each cycle there without ready. When it reaches TIMEOUT_CYCLES, go to DONE with err_o=1, rdata_o=0 and no write merge.
- Undefined: no counter; RD/WR wait indefinitely.

Test Plan:
- Reset mid-RD (ce_o=1), rst pulse -> ce_o=0 same cycle, done_o never pulses, busy_o=0.
- SW addr=0x00000010 data=0xDEADBEEF -> one WR access with ram_addr_o=0x10, ram_data_o=0xDEADBEEF; done_o err=0 two edges after accept.
- Memory word 0x80FF7F01 at 0x20:
  - LB 0x23 -> rdata=0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
  - LH 0x20 -> 0x00007F01.
  - LHU 0x22 -> 0x000080FF.
- SB addr=0x21 wdata=0x000000AA over word 0x11223344 -> RD, GAP (ce=0), WR with ram_data_o=0x1122AA44, done_o after 5 edges.
- LW addr=0x02 and SH addr=0x05 -> done_o=1 and err_o=1 on the edge after accept, ram_ce_o never asserted.
- With RAM_MASTER_TIMEOUT_EN, LW and ram_ready_i held 0 -> done_o and err_o at cycle 15 of RD, rdata=0, then back to IDLE.

Source files
------------

// File: rtl/ram_master.sv
// ram_master: turns one CPU load/store into one or two SRAM driver accesses,
// doing read-modify-write for SB/SH and aligning/extending load data.
// Optional macro RAM_MASTER_TIMEOUT_EN adds a per-access watchdog (TIMEOUT_CYCLES).
module ram_master #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic        ram_ready_i,
  input  logic [31:0] ram_data_i
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_word;
  logic        r_err;

  logic        w_misalign, w_is_load, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_merged;

`ifdef RAM_MASTER_TIMEOUT_EN
  localparam logic [3:0] LP_TO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] r_cnt;

  // Watchdog: restarts on every state change, counts cycles spent waiting for ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   r_cnt <= 4'd0;
    else if (w_next != r_state)                                r_cnt <= 4'd0;
    else if ((r_state == S_RD || r_state == S_WR) && !ram_ready_i) r_cnt <= r_cnt + 4'd1;
  end

  assign w_timeout = (r_state == S_RD || r_state == S_WR) && !ram_ready_i && (r_cnt == LP_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Alignment check on the incoming request (words on 4, halfwords on 2)
  always_comb begin
    w_misalign = 1'b0;
    case (op_i)
      OP_LW, OP_SW:         w_misalign = (addr_i[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misalign = addr_i[0];
      default:              w_misalign = 1'b0;
    endcase
  end

  assign w_is_load = (r_op <= OP_LBU);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: loads/sub-word stores read first, SW writes directly, errors skip the driver
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_i) begin
        if (w_misalign)        w_next = S_DONE;
        else if (op_i == OP_SW) w_next = S_WR;
        else                    w_next = S_RD;
      end
      S_RD: begin
        if (ram_ready_i)    w_next = w_is_load ? S_DONE : S_GAP;
        else if (w_timeout) w_next = S_DONE;
      end
      S_GAP:   w_next = S_WR;
      S_WR:    if (ram_ready_i || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, read capture and sub-word merge into the working word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_i) begin
          r_op    <= op_i;
          r_addr  <= addr_i;
          r_wdata <= wdata_i;
          r_word  <= (op_i == OP_SW) ? wdata_i : 32'd0;
          r_err   <= w_misalign;
        end
        S_RD: begin
          if (ram_ready_i)    r_word <= ram_data_i;
          else if (w_timeout) r_err  <= 1'b1;
        end
        S_GAP: r_word <= w_merged;
        S_WR:  if (!ram_ready_i && w_timeout) r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Lane selection (little-endian) and load extension
  always_comb begin
    w_byte = r_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      2'd3:    w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
    w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];
    w_ext  = 32'd0;
    case (r_op)
      OP_LW:   w_ext = r_word;
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'd0, w_half};
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'd0, w_byte};
      default: w_ext = 32'd0;
    endcase
  end

  // Store merge: only the addressed lane(s) are replaced, the rest keep the read value
  always_comb begin
    w_merged = r_word;
    if (r_op == OP_SB) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: ;
      endcase
    end else if (r_op == OP_SH) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end
  end

  assign ram_ce_o   = (r_state == S_RD) || (r_state == S_WR);
  assign ram_we_o   = (r_state == S_WR);
  assign ram_addr_o = {r_addr[31:2], 2'b00};
  assign ram_data_o = (r_state == S_WR) ? r_word : 32'd0;
  assign done_o     = (r_state == S_DONE);
  assign err_o      = (r_state == S_DONE) && r_err;
  assign busy_o     = (r_state != S_IDLE);
  assign rdata_o    = ((r_state == S_DONE) && !r_err && w_is_load) ? w_ext : 32'd0;

endmodule
